// File: rtl/vmul_pkg.sv
// Shared definitions for the streaming byte multiplier.
//   BYTE_W  : operand / output byte width
//   PROD_W  : full product width
//   state_e : control FSM states
package vmul_pkg;

  localparam int BYTE_W = 8;
  localparam int PROD_W = 2 * BYTE_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    MUL    = 3'd2,
    SEND_0 = 3'd3,
    SEND_1 = 3'd4
  } state_e;

endpackage

// File: rtl/i8bit_mul.sv
// Combinational 8x8 unsigned multiplier.
//   a, b : operands
//   s    : product[7:0]
//   s1   : product[15:8]
module i8bit_mul
  import vmul_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] s,
  output logic [BYTE_W-1:0] s1
);

  logic [PROD_W-1:0] p;

  assign p  = PROD_W'(a) * PROD_W'(b);
  assign s  = p[BYTE_W-1:0];
  assign s1 = p[PROD_W-1:BYTE_W];

endmodule

// File: rtl/vmul_stream_if.sv
// Streaming byte multiplier: accepts operand A then B on a valid/ready input
// stream, multiplies them (unsigned), and emits the 16-bit product as two
// bytes on a valid/ready output stream. One operation in flight at a time.
//   clk, rst_n          : clock, async active-low reset
//   ena                 : gates operand acceptance only
//   in_data/valid/ready : operand stream (A first, then B)
//   out_data/valid/ready: product byte stream
//   out_hi              : current out_data is product[15:8]
//   busy                : FSM not in IDLE
//   op_count            : completed products, wraps at 256
//   HI_FIRST            : 1 = send product high byte first
module vmul_stream_if
  import vmul_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hi,
  output logic              busy,
  output logic [BYTE_W-1:0] op_count
);

  state_e            state, state_nxt;
  logic [BYTE_W-1:0] a_q, b_q, cnt_q;
  logic [PROD_W-1:0] prod_q;
  logic [BYTE_W-1:0] mul_lo, mul_hi;
  logic              xfer;

  i8bit_mul u_mul (
    .a  (a_q),
    .b  (b_q),
    .s  (mul_lo),
    .s1 (mul_hi)
  );

  // rst_n is folded in so in_ready reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign in_ready = rst_n & ena & ((state == IDLE) || (state == LOAD_B));
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer)      state_nxt = LOAD_B;
      LOAD_B:  if (xfer)      state_nxt = MUL;
      MUL:                    state_nxt = SEND_0;
      SEND_0:  if (out_ready) state_nxt = SEND_1;
      SEND_1:  if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && xfer)   a_q    <= in_data;
      if (state == LOAD_B && xfer) b_q    <= in_data;
      if (state == MUL)            prod_q <= {mul_hi, mul_lo};
      if (state == SEND_1 && out_ready) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Outputs decode from registered state/product only, so nothing on the
  // input side reaches out_* combinationally.
  always_comb begin
    out_valid = 1'b0;
    out_hi    = 1'b0;
    if (state == SEND_0) begin
      out_valid = 1'b1;
      out_hi    = HI_FIRST;
    end else if (state == SEND_1) begin
      out_valid = 1'b1;
      out_hi    = ~HI_FIRST;
    end
  end

  assign out_data = !out_valid ? '0 :
                    out_hi     ? prod_q[PROD_W-1:BYTE_W] : prod_q[BYTE_W-1:0];
  assign busy     = (state != IDLE);
  assign op_count = cnt_q;

endmodule

// File: tb/tb_vmul_stream_if.sv
// Bench for vmul_stream_if: two instances (low-first and high-first) share
// the same stimulus; expected bytes are queued per instance when an operation
// is issued and a negedge monitor pops/compares whenever a byte is consumed.
module tb_vmul_stream_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       ir [2];
  logic [7:0] od [2];
  logic       ov [2];
  logic       oh [2];
  logic       bz [2];
  logic [7:0] oc [2];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_cnt = 8'h00;

  typedef struct packed { logic [7:0] d; logic hi; } exp_t;
  exp_t q [2][$];

  bit force_en  = 1'b1;
  bit force_val = 1'b1;

  always #5 clk = ~clk;

  vmul_stream_if #(.HI_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_hi(oh[0]), .busy(bz[0]), .op_count(oc[0])
  );

  vmul_stream_if #(.HI_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_hi(oh[1]), .busy(bz[1]), .op_count(oc[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Consumer: forced level or random back-pressure.
  always @(posedge clk) begin
    #1;
    out_ready = force_en ? force_val : 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ov[i]) begin
        if (out_ready) begin
          if (q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte dut%0d actual=0x%0h expected=none", i, od[i]);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("out_data_dut%0d", i), {8'h00, od[i]}, {8'h00, e.d});
            chk($sformatf("out_hi_dut%0d", i), {15'h0, oh[i]}, {15'h0, e.hi});
          end
        end
        chk($sformatf("no_overlap_dut%0d", i), {15'h0, ir[i]}, 16'h0);
      end else begin
        chk($sformatf("idle_data_dut%0d", i), {8'h00, od[i]}, 16'h0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (ir[0]) break;
      if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout actual=0 expected=1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // B transfer, latency check, and queueing of expected bytes.
  task automatic finish_b(input logic [7:0] b, input logic [15:0] p);
    q[0].push_back('{d: p[7:0],  hi: 1'b0});
    q[0].push_back('{d: p[15:8], hi: 1'b1});
    q[1].push_back('{d: p[15:8], hi: 1'b1});
    q[1].push_back('{d: p[7:0],  hi: 1'b0});
    send_byte(b);
    chk("latency_mul_cycle", {15'h0, ov[0]}, 16'h0);
    @(posedge clk);
    #1;
    chk("latency_first_valid", {15'h0, ov[0]}, 16'h1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    send_byte(a);
    finish_b(b, p);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bz[0]) begin
      @(posedge clk);
      #1;
      if (++n > 300) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout actual=1 expected=0");
        break;
      end
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    issue(a, b, p);
    wait_idle();
    exp_cnt = exp_cnt + 8'd1;
    chk("op_count", {8'h00, oc[0]}, {8'h00, exp_cnt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    // Reset state with ena and in_valid high.
    ena = 1'b1;
    in_valid = 1'b1;
    #12;
    chk("rst_in_ready", {15'h0, ir[0]}, 16'h0);
    chk("rst_out_valid", {15'h0, ov[0]}, 16'h0);
    chk("rst_out_hi", {15'h0, oh[1]}, 16'h0);
    chk("rst_busy", {15'h0, bz[0]}, 16'h0);
    chk("rst_op_count", {8'h00, oc[0]}, 16'h0);
    chk("rst_out_data", {8'h00, od[0]}, 16'h0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(8'h12, 8'h34, 16'h03A8);
    do_op(8'hFF, 8'hFF, 16'hFE01);

    // Back-pressure: output held for 5 cycles.
    force_val = 1'b0;
    issue(8'h0F, 8'h0F, 16'h00E1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {15'h0, ov[0]}, 16'h1);
      chk("stall_data", {8'h00, od[0]}, 16'h00E1);
    end
    force_val = 1'b1;
    wait_idle();
    exp_cnt = exp_cnt + 8'd1;
    chk("op_count_stall", {8'h00, oc[0]}, {8'h00, exp_cnt});

    // ena gating in IDLE and with A held in LOAD_B.
    ena = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h99;
    repeat (3) begin
      @(negedge clk);
      chk("ena0_idle_ready", {15'h0, ir[0]}, 16'h0);
      chk("ena0_idle_busy", {15'h0, bz[0]}, 16'h0);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    send_byte(8'h07);
    ena = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("ena0_loadb_ready", {15'h0, ir[0]}, 16'h0);
      chk("ena0_loadb_busy", {15'h0, bz[0]}, 16'h1);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    finish_b(8'h03, 16'h0015);
    wait_idle();
    exp_cnt = exp_cnt + 8'd1;
    chk("op_count_ena", {8'h00, oc[0]}, {8'h00, exp_cnt});

    // Reset pulse while in SEND_1.
    force_val = 1'b0;
    issue(8'h0C, 8'h0B, 16'h0084);
    force_val = 1'b1;
    @(posedge clk);
    #2 force_val = 1'b0;
    @(posedge clk);
    #2;
    chk("in_send1_hi", {15'h0, oh[0]}, 16'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {15'h0, ov[0]}, 16'h0);
    chk("midrst_busy", {15'h0, bz[0]}, 16'h0);
    chk("midrst_op_count", {8'h00, oc[0]}, 16'h0);
    q[0].delete();
    q[1].delete();
    exp_cnt = 8'h00;
    #3 rst_n = 1'b1;
    force_val = 1'b1;
    @(posedge clk);
    #1;
    do_op(8'h0C, 8'h0B, 16'h0084);

    // Randomized operands under random back-pressure.
    force_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, 16'(ra) * 16'(rb));
    end
    force_en = 1'b1;

    // 256 back-to-back zero products from a fresh count.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_cnt = 8'h00;
    for (int i = 0; i < 256; i++) do_op(8'h00, 8'hAB, 16'h0000);
    chk("wrap_op_count", {8'h00, oc[0]}, 16'h0);
    chk("wrap_op_count_hi_first", {8'h00, oc[1]}, 16'h0);

    repeat (3) @(posedge clk);
    chk("queue0_drained", 16'(q[0].size()), 16'h0);
    chk("queue1_drained", 16'(q[1].size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
